// File: rtl/ising_host_ctrl.sv
// -----------------------------------------------------------------------------
// ising_host_ctrl
//
// Host-side job sequencer for an Ising annealing core. A job writes the
// halt/cutoff/max/weight registers and the go bit over a simple write strobe
// port, waits run_cycles clocks for the anneal, then reads back one phase bit
// per spin over a single-outstanding read channel and pulses done.
//
// Parameters
//   N            spin count
//   NUM_WEIGHTS  width of each coupling weight field
//   P            coupling count N*(N-1)/2 (derived, not overridable)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    job request (only sampled in IDLE)
//   weights_in               coupling i in bits [i*NUM_WEIGHTS +: NUM_WEIGHTS]
//   counter_cutoff_in        value written to the cutoff register
//   counter_max_in           value written to the max register
//   run_cycles               anneal wait length in clk cycles
//   arvalid_q, araddr_q      read request strobe and address
//   rready                   read data accept
//   rvalid, rresp, rdata     read data valid, read error, read data
//   wready, wr_addr, wdata   write strobe, address and data
//   busy                     high in every state except IDLE
//   done                     one-cycle job-complete pulse
//   err                      sticky job error, cleared at job start
//   phase_out                captured spin phases
//
// Configuration
//   ISING_HOST_RD_TIMEOUT_EN  when defined, a read that sees no rvalid for
//                             16 consecutive RD_WAIT cycles ends the job with
//                             err set. Undefined: RD_WAIT waits forever.
// -----------------------------------------------------------------------------
module ising_host_ctrl #(
  parameter int N           = 3,
  parameter int NUM_WEIGHTS = 5,
  localparam int P          = N * (N - 1) / 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_WEIGHTS*P-1:0]   weights_in,
  input  logic [31:0]                counter_cutoff_in,
  input  logic [31:0]                counter_max_in,
  input  logic [31:0]                run_cycles,
  output logic                       arvalid_q,
  output logic [31:0]                araddr_q,
  output logic                       rready,
  input  logic                       rvalid,
  input  logic                       rresp,
  input  logic [31:0]                rdata,
  output logic                       wready,
  output logic [31:0]                wr_addr,
  output logic [31:0]                wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [N-1:0]               phase_out
);

  localparam logic [31:0] ADDR_START       = 32'h0000_0500;
  localparam logic [31:0] ADDR_CUTOFF      = 32'h0000_0600;
  localparam logic [31:0] ADDR_MAX         = 32'h0000_0700;
  localparam logic [31:0] ADDR_PHASE_BASE  = 32'h0000_0800;
  localparam logic [31:0] ADDR_WEIGHT_BASE = 32'h0000_1000;

  localparam int WIDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int JW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(P - 1);
  localparam logic [JW-1:0]     J_LAST    = JW'(N - 1);

  typedef enum logic [3:0] {
    IDLE, WR_HALT, WR_CUTOFF, WR_MAX, WR_WEIGHT, WR_GO, RUN, RD_REQ, RD_WAIT, DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDX_W-1:0]        widx_q, widx_d;
  logic [JW-1:0]            ridx_q, ridx_d;
  logic [31:0]              run_cnt_q, run_cnt_d;

  // Job parameters captured when the job is accepted.
  logic [NUM_WEIGHTS*P-1:0] weights_q;
  logic [31:0]              cutoff_q, max_q, run_len_q;

  logic                     wready_q, rready_q, busy_q, done_q, err_q;
  logic [31:0]              wr_addr_q, wdata_q;
  logic [N-1:0]             phase_q;

  logic                     job_accept;
  logic                     rd_fire;
  logic                     unused_rdata;

  assign job_accept   = (state_q == IDLE) && start;
  // rready_q is high exactly in RD_WAIT, so rvalid elsewhere never fires.
  assign rd_fire      = (state_q == RD_WAIT) && rready_q && rvalid;
  assign unused_rdata = ^rdata[31:1];

`ifdef ISING_HOST_RD_TIMEOUT_EN
  localparam int TMO_CYCLES = 16;
  logic [4:0] tmo_q;
  logic       rd_timeout;
  // tmo_q counts RD_WAIT cycles already spent, so the 16th silent cycle ends the read.
  assign rd_timeout = (state_q == RD_WAIT) && !rvalid && (tmo_q == 5'(TMO_CYCLES - 1));
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d   = state_q;
    widx_d    = widx_q;
    ridx_d    = ridx_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      IDLE:      if (start) state_d = WR_HALT;
      WR_HALT:   state_d = WR_CUTOFF;
      WR_CUTOFF: state_d = WR_MAX;
      WR_MAX: begin
        state_d = WR_WEIGHT;
        widx_d  = '0;
      end
      WR_WEIGHT: begin
        if (widx_q == WIDX_LAST) state_d = WR_GO;
        else                     widx_d  = widx_q + 1'b1;
      end
      WR_GO: begin
        // RUN lasts exactly run_len_q cycles; a zero length skips it entirely.
        ridx_d = '0;
        if (run_len_q == 32'd0) begin
          state_d = RD_REQ;
        end else begin
          state_d   = RUN;
          run_cnt_d = run_len_q - 32'd1;
        end
      end
      RUN: begin
        if (run_cnt_q == 32'd0) state_d   = RD_REQ;
        else                    run_cnt_d = run_cnt_q - 32'd1;
      end
      RD_REQ:    state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_fire) begin
          if (ridx_q == J_LAST) begin
            state_d = DONE;
          end else begin
            ridx_d  = ridx_q + 1'b1;
            state_d = RD_REQ;
          end
        end
`ifdef ISING_HOST_RD_TIMEOUT_EN
        else if (rd_timeout) begin
          state_d = DONE;
        end
`endif
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs. Outputs are decoded from state_d
  // so they are valid in the same cycle the FSM sits in the matching state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears every register, phase_out included, so an aborted
      // job leaves no stale phase bits or strobes behind.
      state_q   <= IDLE;
      widx_q    <= '0;
      ridx_q    <= '0;
      run_cnt_q <= '0;
      weights_q <= '0;
      cutoff_q  <= '0;
      max_q     <= '0;
      run_len_q <= '0;
      wready_q  <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      phase_q   <= '0;
`ifdef ISING_HOST_RD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge value of every other register.
      state_q   <= state_d;
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      run_cnt_q <= run_cnt_d;

      if (job_accept) begin
        weights_q <= weights_in;
        cutoff_q  <= counter_cutoff_in;
        max_q     <= counter_max_in;
        run_len_q <= run_cycles;
        err_q     <= 1'b0;
      end else if (rd_fire && rresp) begin
        err_q <= 1'b1;
      end
`ifdef ISING_HOST_RD_TIMEOUT_EN
      else if (rd_timeout) begin
        err_q <= 1'b1;
      end
      tmo_q <= (state_q == RD_WAIT) ? tmo_q + 5'd1 : 5'd0;
`endif

      if (rd_fire) phase_q[ridx_q] <= rdata[0];

      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      arvalid_q <= (state_d == RD_REQ);
      rready_q  <= (state_d == RD_WAIT);
      wready_q  <= (state_d inside {WR_HALT, WR_CUTOFF, WR_MAX, WR_WEIGHT, WR_GO});

      wr_addr_q <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      case (state_d)
        WR_HALT:   wr_addr_q <= ADDR_START;
        WR_CUTOFF: begin
          wr_addr_q <= ADDR_CUTOFF;
          wdata_q   <= cutoff_q;
        end
        WR_MAX: begin
          wr_addr_q <= ADDR_MAX;
          wdata_q   <= max_q;
        end
        WR_WEIGHT: begin
          wr_addr_q <= ADDR_WEIGHT_BASE + (32'(widx_d) << 5);
          wdata_q   <= 32'(weights_q[int'(widx_d)*NUM_WEIGHTS +: NUM_WEIGHTS]);
        end
        WR_GO: begin
          wr_addr_q <= ADDR_START;
          wdata_q   <= 32'd1;
        end
        RD_REQ:    araddr_q <= ADDR_PHASE_BASE + (32'(ridx_d) << 5);
        default:   ;
      endcase
    end
  end

  assign wready    = wready_q;
  assign wr_addr   = wr_addr_q;
  assign wdata     = wdata_q;
  assign rready    = rready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign phase_out = phase_q;

endmodule

// File: tb/tb_ising_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ising_host_ctrl
//
// Scoreboard bench for ising_host_ctrl. Each job pushes its expected write
// sequence, read addresses, GO-to-first-read delay and final phase/err into
// queues; a monitor pops and compares whenever the DUT strobes wready,
// arvalid_q or done. A responder answers reads with programmable data, error,
// latency, ignored rvalid glitches and write-phase rvalid noise.
// -----------------------------------------------------------------------------
module tb_ising_host_ctrl;

  localparam int N  = 3;
  localparam int NW = 5;
  localparam int P  = N * (N - 1) / 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [N-1:0] phase;
    logic         err;
    bit           tmo;
  } done_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NW*P-1:0]   weights_in;
  logic [31:0]       counter_cutoff_in, counter_max_in, run_cycles;
  logic              arvalid_q, rready, wready, busy, done, err;
  logic [31:0]       araddr_q, wr_addr, wdata;
  logic              rvalid = 1'b0;
  logic              rresp  = 1'b0;
  logic [31:0]       rdata  = '0;
  logic [N-1:0]      phase_out;

  ising_host_ctrl #(.N(N), .NUM_WEIGHTS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .weights_in(weights_in),
    .counter_cutoff_in(counter_cutoff_in), .counter_max_in(counter_max_in),
    .run_cycles(run_cycles), .arvalid_q(arvalid_q), .araddr_q(araddr_q),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues and reference model state.
  wr_t          exp_wr[$];
  logic [31:0]  exp_rd[$];
  int           exp_delay[$];
  done_t        exp_done[$];
  logic [N-1:0] model_phase = '0;

  // Responder controls (written by stimulus only).
  logic [N-1:0] resp_bits = '0;
  logic [N-1:0] resp_err  = '0;
  bit           resp_on   = 1'b1;
  bit           glitch_en = 1'b0;
  bit           noise_en  = 1'b0;
  int           gap_max   = 0;

  // Reference model: the job's bus traffic follows directly from its inputs.
  task automatic push_job(input logic [NW*P-1:0] w, input logic [31:0] cut, mx, rc,
                          input logic [N-1:0] bits, errs, input bit tmo);
    done_t d;
    exp_wr.push_back('{32'h500, 32'd0});
    exp_wr.push_back('{32'h600, cut});
    exp_wr.push_back('{32'h700, mx});
    for (int i = 0; i < P; i++)
      exp_wr.push_back('{32'h1000 + 32'(32 * i), 32'(w[i*NW +: NW])});
    exp_wr.push_back('{32'h500, 32'd1});
    exp_delay.push_back(int'(rc) + 1);
    if (tmo) begin
      exp_rd.push_back(32'h800);
      d = '{model_phase, 1'b1, 1'b1};
    end else begin
      for (int j = 0; j < N; j++) exp_rd.push_back(32'h800 + 32'(32 * j));
      model_phase = bits;
      d = '{bits, |errs, 1'b0};
    end
    exp_done.push_back(d);
  endtask

  // Monitor: compares every strobe against the scoreboard, one cycle at a time.
  longint last_wr_cyc = 0;
  longint go_cyc      = 0;
  longint last_ar_cyc = 0;
  bit     first_rd_pending = 1'b0;

  always begin
    wr_t   w;
    done_t d;
    @(posedge clk); #1;
    if (rst === 1'b1) first_rd_pending = 1'b0;
    if (wready === 1'b1) begin
      check("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", wdata, w.data);
        if (!(w.addr == 32'h500 && w.data == 32'd0))
          check("wr_gapless", cyc - last_wr_cyc, 1);
        if (w.addr == 32'h500 && w.data == 32'd1) begin
          go_cyc = cyc;
          first_rd_pending = 1'b1;
        end
      end
      last_wr_cyc = cyc;
    end
    if (arvalid_q === 1'b1) begin
      check("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) check("araddr", araddr_q, exp_rd.pop_front());
      check("rd_one_outstanding", rready, 0);
      if (first_rd_pending && exp_delay.size() != 0)
        check("go_to_first_read", cyc - go_cyc, 64'(exp_delay.pop_front()));
      first_rd_pending = 1'b0;
      last_ar_cyc = cyc;
    end
    if (done === 1'b1) begin
      check("done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        d = exp_done.pop_front();
        check("phase_out", phase_out, d.phase);
        check("err", err, d.err);
        check("busy_in_done", busy, 1);
        if (d.tmo) check("timeout_latency", cyc - last_ar_cyc, 17);
      end
    end
    if (busy === 1'b0) begin
      check("idle_strobes", {wready, arvalid_q, rready, done}, 0);
      check("idle_buses", wr_addr | wdata | araddr_q, 0);
    end
  end

  // Responder: one read at a time, reply after 1+gap cycles.
  int resp_idx = 0;
  always begin
    int gap;
    @(posedge clk); #1;
    rvalid = 1'b0;
    rresp  = 1'b0;
    rdata  = $urandom;
    if (wready === 1'b1 && wr_addr == 32'h500 && wdata == 32'd0) resp_idx = 0;
    if (noise_en && wready === 1'b1 && $urandom_range(0, 2) == 0) begin
      rvalid = 1'b1;
      rresp  = 1'b1;
    end
    if (arvalid_q === 1'b1 && resp_on) begin
      if (glitch_en && $urandom_range(0, 1) == 1) begin
        rvalid   = 1'b1;
        rresp    = 1'b1;
        rdata[0] = ~resp_bits[resp_idx];
      end
      gap = $urandom_range(0, gap_max);
      @(posedge clk); #1;
      rvalid = 1'b0;
      rresp  = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      rvalid   = 1'b1;
      rdata    = $urandom;
      rdata[0] = resp_bits[resp_idx];
      rresp    = resp_err[resp_idx];
      resp_idx = (resp_idx + 1) % N;
    end
  end

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < 300) begin @(posedge clk); #2; t++; end
    check(name, done, 1);
  endtask

  task automatic launch(input logic [NW*P-1:0] w, input logic [31:0] cut, mx, rc,
                        input logic [N-1:0] bits, errs, input bit tmo);
    push_job(w, cut, mx, rc, bits, errs, tmo);
    resp_bits = bits;
    resp_err  = errs;
    resp_on   = !tmo;
    @(posedge clk); #2;
    start             = 1'b1;
    weights_in        = w;
    counter_cutoff_in = cut;
    counter_max_in    = mx;
    run_cycles        = rc;
    @(posedge clk); #2;
    check("start_to_halt_write", {busy, wready, wr_addr}, {1'b1, 1'b1, 32'h500});
  endtask

  task automatic do_job(input logic [NW*P-1:0] w, input logic [31:0] cut, mx, rc,
                        input logic [N-1:0] bits, errs, input bit tmo, input bit scramble);
    launch(w, cut, mx, rc, bits, errs, tmo);
    start = 1'b0;
    if (scramble) begin
      // Values already latched; changing them now must not affect the job.
      weights_in        = NW*P'($urandom);
      counter_cutoff_in = $urandom;
      counter_max_in    = $urandom;
      run_cycles        = $urandom_range(50, 90);
    end
    wait_done("job_completes");
    @(posedge clk); #2;
    check("back_to_idle", busy, 0);
  endtask

  function automatic logic [NW*P-1:0] rand_weights();
    logic [NW*P-1:0] w;
    for (int i = 0; i < P; i++) w[i*NW +: NW] = NW'($urandom);
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW*P-1:0] w;
    int              t;
    rst = 1'b1; start = 1'b0; weights_in = '0;
    counter_cutoff_in = '0; counter_max_in = '0; run_cycles = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_strobes", {busy, done, err, wready, arvalid_q, rready}, 0);
    check("reset_phase", phase_out, 0);
    check("reset_buses", wr_addr | wdata | araddr_q, 0);
    rst = 1'b0;

    // Basic job: weights 4,4,4, cutoff 10, max 100, 5 run cycles, reads 1,0,1.
    w = {5'd4, 5'd4, 5'd4};
    do_job(w, 32'd10, 32'd100, 32'd5, 3'b101, 3'b000, 1'b0, 1'b0);
    check("basic_phase_hold", phase_out, 3'b101);

    // Zero anneal wait.
    do_job(rand_weights(), 32'd7, 32'd9, 32'd0, 3'b010, 3'b000, 1'b0, 1'b0);

    // Read error on the second read still completes all reads.
    do_job(rand_weights(), 32'd1, 32'd2, 32'd3, 3'b011, 3'b010, 1'b0, 1'b0);

    // Next job clears the sticky error.
    do_job(rand_weights(), 32'd3, 32'd4, 32'd1, 3'b110, 3'b000, 1'b0, 1'b1);

    // Start held high: one job, one IDLE cycle, then exactly one more job.
    w = rand_weights();
    push_job(w, 32'h55, 32'hAA, 32'd2, 3'b001, 3'b000, 1'b0);
    launch(w, 32'h55, 32'hAA, 32'd2, 3'b001, 3'b000, 1'b0);
    wait_done("busy_start_first_done");
    @(posedge clk); #2;
    check("busy_start_idle_gap", busy, 0);
    @(posedge clk); #2;
    check("busy_start_second_job", {busy, wready, wr_addr}, {1'b1, 1'b1, 32'h500});
    start = 1'b0;
    wait_done("busy_start_second_done");
    repeat (20) @(posedge clk);
    #2;
    check("busy_start_no_third_job", busy, 0);

    // Randomized jobs with latency, ignored glitches and write-phase noise.
    glitch_en = 1'b1;
    noise_en  = 1'b1;
    gap_max   = 3;
    for (int k = 0; k < 10; k++) begin
      do_job(rand_weights(), $urandom, $urandom, 32'($urandom_range(0, 6)),
             N'($urandom), ($urandom_range(0, 2) == 0) ? N'($urandom) : '0, 1'b0, 1'b1);
    end
    glitch_en = 1'b0;
    noise_en  = 1'b0;
    gap_max   = 0;

`ifdef ISING_HOST_RD_TIMEOUT_EN
    // Silent responder: timeout ends the job with err and phase_out unchanged.
    do_job(rand_weights(), 32'd5, 32'd6, 32'd2, '0, '0, 1'b1, 1'b0);
    resp_on = 1'b1;
`endif

    // Reset during the second weight write aborts the job cleanly.
    w = rand_weights();
    launch(w, 32'd11, 32'd22, 32'd4, 3'b111, 3'b000, 1'b0);
    start = 1'b0;
    t = 0;
    while (!(wready === 1'b1 && wr_addr == 32'h1020) && t < 50) begin
      @(posedge clk); #2; t++;
    end
    check("reach_weight1", {wready, wr_addr}, {1'b1, 32'h1020});
    rst = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    exp_delay.delete();
    exp_done.delete();
    model_phase = '0;
    @(posedge clk); #2;
    check("rst_mid_job_strobes", {wready, busy, done}, 0);
    check("rst_mid_job_phase_err", {phase_out, err}, 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("rst_mid_job_stays_idle", busy, 0);

    // Job after abort runs normally.
    do_job(rand_weights(), 32'd8, 32'd16, 32'd3, 3'b100, 3'b000, 1'b0, 1'b0);

    check("sb_writes_drained", exp_wr.size(), 0);
    check("sb_reads_drained", exp_rd.size(), 0);
    check("sb_done_drained", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ising_host_ctrl.md
ISING_HOST_CTRL -- requirements
Module: ising_host_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- N, 3: spin count.
- NUM_WEIGHTS, 5: weight field width (odd).
- P (derived, not overridable) = N*(N-1)/2: coupling count.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports, in order:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: job request.
- weights_in, in, NUM_WEIGHTS*P: coupling i in bits [i*NUM_WEIGHTS +: NUM_WEIGHTS].
- counter_cutoff_in, in, 32: value for cutoff register.
- counter_max_in, in, 32: value for max register.
- run_cycles, in, 32: anneal wait length in clk cycles.
- arvalid_q, out, 1: read request strobe.
- araddr_q, out, 32: read address.
- rready, out, 1: read-data accept.
- rvalid, in, 1: read data valid.
- rresp, in, 1: read error.
- rdata, in, 32: read data.
- wready, out, 1: write strobe.
- wr_addr, out, 32: write address.
- wdata, out, 32: write data.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle job-complete pulse.
- err, out, 1: sticky job error.
- phase_out, out, N: captured spin phases.

Function
REQ-003 Address map SHALL be:
- START 0x500.
- CUTOFF 0x600.
- MAX 0x700.
- Phase bit j at 0x800 + 32*j.
- Weight i at 0x1000 + 32*i.
REQ-004 FSM states SHALL be IDLE, WR_HALT, WR_CUTOFF, WR_MAX, WR_WEIGHT, WR_GO, RUN, RD_REQ, RD_WAIT, DONE.
REQ-005 IDLE SHALL move to WR_HALT on start=1; start SHALL be ignored in every other state.
REQ-006 On leaving IDLE, the block SHALL latch weights_in, counter_cutoff_in, counter_max_in and run_cycles, and SHALL clear err.
REQ-007 Each WR_* state SHALL last exactly one cycle, with wready=1 and wr_addr/wdata valid in that cycle only.
REQ-008 Write data per state SHALL be:
- WR_HALT: START, 0.
- WR_CUTOFF: CUTOFF, cutoff.
- WR_MAX: MAX, max.
- WR_WEIGHT: P consecutive cycles, i=0..P-1, weight i zero-extended to 32 bits.
- WR_GO: START, 1.
REQ-009 Total write phase SHALL be P+4 cycles with no gaps.
REQ-010 RUN SHALL count down the latched run_cycles and go to RD_REQ once the count reaches 0; run_cycles=0 SHALL go to RD_REQ the next cycle.
REQ-011 RD_REQ SHALL hold arvalid_q=1 for exactly one cycle with araddr_q=0x800+32*j, then go to RD_WAIT.
REQ-012 RD_WAIT SHALL hold rready=1 and arvalid_q=0.
REQ-013 On rvalid&&rready, the block SHALL:
- capture rdata[0] into phase_out[j];
- set err if rresp=1;
- with j<N-1: increment j and go to RD_REQ;
- otherwise: go to DONE.
REQ-014 Reads SHALL be issued in order j=0..N-1, with at most one read outstanding.
REQ-015 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 When idle, wready, arvalid_q and rready SHALL be 0, and wr_addr, wdata and araddr_q SHALL be 0.
REQ-018 phase_out SHALL hold its value until the next job's first capture.
REQ-019 rvalid arriving outside RD_WAIT SHALL be ignored.

Reset
REQ-020 While rst=1 at a clk edge, the block SHALL enter IDLE and zero all outputs, j and the run counter; this includes phase_out, err and done.
REQ-021 Reset mid-job SHALL abort the job with no further strobes and no done pulse.

Configuration
REQ-022 With macro ISING_HOST_RD_TIMEOUT_EN defined, the block SHALL count cycles in RD_WAIT.
REQ-023 Under ISING_HOST_RD_TIMEOUT_EN, if rvalid is absent for 16 consecutive RD_WAIT cycles, the block SHALL set err=1, pulse done and return to IDLE, leaving the remaining phase_out bits unchanged.
REQ-024 Without ISING_HOST_RD_TIMEOUT_EN, RD_WAIT SHALL wait indefinitely and no timeout logic SHALL exist.

Verification
REQ-025 Basic job. Stimulus: N=3, weights {5'd4,5'd4,5'd4}, cutoff 10, max 100, run_cycles 5, responder replying rdata[0]=1,0,1 one cycle after each arvalid_q. Required response:
- writes (0x500,0), (0x600,10), (0x700,100), (0x1000,4), (0x1020,4), (0x1040,4), (0x500,1) in 7 consecutive cycles;
- reads at 0x800, 0x820, 0x840;
- phase_out=3'b101, done once, err=0.
REQ-026 Zero wait: run_cycles=0 SHALL issue the first arvalid_q 1 cycle after the WR_GO write.
REQ-027 Read error: rresp=1 on the second read SHALL still complete all 3 reads, with done=1 and err=1.
REQ-028 Busy start: start held high through the whole job SHALL produce exactly one job, plus a second job only after the return to IDLE.
REQ-029 Reset mid-job: rst asserted during the WR_WEIGHT i=1 cycle SHALL produce, on the next cycle, wready=0, busy=0 and no done pulse.
REQ-030 Timeout (ISING_HOST_RD_TIMEOUT_EN defined): a responder that never asserts rvalid SHALL produce done and err=1 exactly 16 RD_WAIT cycles after the first arvalid_q.
